im_read_arb: RTL and testbench

IM_READ_ARB -- requirements
Module: im_read_arb

---
 rtl/im_read_arb.sv | 110 +++++++++++
 tb/tb_im_read_arb.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/im_read_arb.sv
// Instruction-memory read arbiter: CPU fetch port and debug readback port share one
// memory read path, with a starvation counter that promotes a waiting debug request.
module im_read_arb #(
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [13:0] cpu_addr,
    output logic        cpu_gnt,
    output logic        cpu_vld,
    output logic [15:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic [13:0] dbg_addr,
    output logic        dbg_gnt,
    output logic        dbg_vld,
    output logic [15:0] dbg_rdata,
    output logic        im_rd_en,
    output logic [13:0] im_addr,
    input  logic [15:0] im_instr
);

    localparam int         DATA_W = 16;
    localparam logic [3:0] SMAX   = 4'(STARVE_MAX);

    typedef enum logic {
        CPU_PRI = 1'b0,
        DBG_PRI = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  starve_cnt, starve_cnt_nxt;

    logic              own_cpu_p1;
    logic              own_dbg_p1;
    logic [DATA_W-1:0] cpu_rdata_p1;
    logic [DATA_W-1:0] dbg_rdata_p1;

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? lim : v + 4'd1;
    endfunction

    // Stage 0: combinational grant, starvation bookkeeping and next-state decode
    always_comb begin
        cpu_gnt        = 1'b0;
        dbg_gnt        = 1'b0;
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;

        // Grants are forced off while reset is held, whatever the requests do.
        if (rst_n) begin
            if (state == DBG_PRI) begin
                dbg_gnt = dbg_req;
                cpu_gnt = cpu_req & ~dbg_req;
            end else begin
                cpu_gnt = cpu_req;
                dbg_gnt = dbg_req & ~cpu_req;
            end
        end

        if (dbg_gnt || !dbg_req)
            starve_cnt_nxt = 4'd0;
        else if (cpu_gnt)
            starve_cnt_nxt = sat_inc(starve_cnt, SMAX);

        // Promotion looks at the updated count so the debug grant lands on the
        // cycle right after the STARVE_MAX-th CPU grant.
        case (state)
            CPU_PRI: if (dbg_req && !dbg_gnt && starve_cnt_nxt >= SMAX) state_nxt = DBG_PRI;
            DBG_PRI: state_nxt = CPU_PRI;
            default: state_nxt = CPU_PRI;
        endcase
    end

    assign im_rd_en = cpu_gnt | dbg_gnt;
    assign im_addr  = dbg_gnt ? dbg_addr : cpu_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CPU_PRI;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Stage 1: owner tag and returned word; memory drove im_instr at the mid-cycle negedge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_cpu_p1   <= 1'b0;
            own_dbg_p1   <= 1'b0;
            cpu_rdata_p1 <= '0;
            dbg_rdata_p1 <= '0;
        end else begin
            own_cpu_p1 <= cpu_gnt;
            own_dbg_p1 <= dbg_gnt;
            if (cpu_gnt)
                cpu_rdata_p1 <= im_instr;
            if (dbg_gnt)
                dbg_rdata_p1 <= im_instr;
        end
    end

    assign cpu_vld   = own_cpu_p1;
    assign dbg_vld   = own_dbg_p1;
    assign cpu_rdata = cpu_rdata_p1;
    assign dbg_rdata = dbg_rdata_p1;

endmodule

// File: tb/tb_im_read_arb.sv
// Randomized bench for im_read_arb against a cycle-level arbitration model and a
// behavioural instruction memory that registers data on the falling edge.
module tb_im_read_arb;

    localparam int SMAX = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic [13:0] cpu_addr = '0;
    logic        cpu_gnt, cpu_vld;
    logic [15:0] cpu_rdata;
    logic        dbg_req = 1'b0;
    logic [13:0] dbg_addr = '0;
    logic        dbg_gnt, dbg_vld;
    logic [15:0] dbg_rdata;
    logic        im_rd_en;
    logic [13:0] im_addr;
    logic [15:0] im_instr = '0;

    im_read_arb #(.STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
        .cpu_vld(cpu_vld), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_vld(dbg_vld), .dbg_rdata(dbg_rdata),
        .im_rd_en(im_rd_en), .im_addr(im_addr), .im_instr(im_instr)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:16383];
    always @(negedge clk) if (im_rd_en) im_instr <= mem[im_addr];

    int total = 0;
    int bad   = 0;

    // Model: whether debug is currently promoted, how many CPU grants it has waited
    // through, and what each read port should show after the next clock edge.
    bit          m_promo;
    int          m_wait;
    bit          e_cv, e_dv;
    logic [15:0] e_cd, e_dd;
    bit          m_gd;
    bit          seen_dgnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_promo = 0; m_wait = 0;
        e_cv = 0; e_dv = 0; e_cd = 16'h0000; e_dd = 16'h0000;
    endtask

    // One clock: drive requests, check outputs mid-cycle, advance the model.
    task automatic cycle(input bit cr, input logic [13:0] ca, input bit dr,
                         input logic [13:0] da, input string tag);
        bit gc, gd;
        cpu_req = cr; cpu_addr = ca; dbg_req = dr; dbg_addr = da;
        @(negedge clk);
        check_eq({tag, "/cpu_vld"},   cpu_vld,   e_cv);
        check_eq({tag, "/cpu_rdata"}, cpu_rdata, e_cd);
        check_eq({tag, "/dbg_vld"},   dbg_vld,   e_dv);
        check_eq({tag, "/dbg_rdata"}, dbg_rdata, e_dd);
        gd = dr && (m_promo || !cr);
        gc = cr && !gd;
        check_eq({tag, "/cpu_gnt"},  cpu_gnt,  gc);
        check_eq({tag, "/dbg_gnt"},  dbg_gnt,  gd);
        check_eq({tag, "/im_rd_en"}, im_rd_en, gc | gd);
        check_eq({tag, "/im_addr"},  im_addr,  gd ? da : ca);
        seen_dgnt = dbg_gnt;
        e_cv = gc; e_dv = gd;
        if (gc) e_cd = mem[ca];
        if (gd) e_dd = mem[da];
        if (gd || !dr) begin
            m_wait = 0; m_promo = 0;
        end else if (gc) begin
            m_wait++;
            if (m_wait >= SMAX) m_promo = 1;
        end
        m_gd = gd;
        @(posedge clk); #1;
    endtask

    initial begin
        int          dcount, first_d;
        bit          d_pend, cr;
        logic [13:0] d_a, c_a;

        for (int i = 0; i < 16384; i++) mem[i] = 16'($urandom);
        mem[14'h0005] = 16'hA5C3;
        mem[14'h0100] = 16'h0100;
        model_reset();

        // Reset held with both requests up: nothing may be granted or returned.
        cpu_req = 1; dbg_req = 1; cpu_addr = 14'h0005; dbg_addr = 14'h0100;
        @(negedge clk);
        check_eq("rst/cpu_gnt",   cpu_gnt,   0);
        check_eq("rst/dbg_gnt",   dbg_gnt,   0);
        check_eq("rst/im_rd_en",  im_rd_en,  0);
        check_eq("rst/cpu_vld",   cpu_vld,   0);
        check_eq("rst/dbg_vld",   dbg_vld,   0);
        check_eq("rst/cpu_rdata", cpu_rdata, 16'h0000);
        check_eq("rst/dbg_rdata", dbg_rdata, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1;

        // Single CPU fetch of word 5.
        cycle(1, 14'h0005, 0, 14'h0000, "cpu5");
        check_eq("cpu5/vld_now",   cpu_vld,   1);
        check_eq("cpu5/data_now",  cpu_rdata, 16'hA5C3);
        check_eq("cpu5/dbg_quiet", dbg_vld,   0);
        cycle(0, 14'h0000, 0, 14'h0000, "cpu5_idle");

        // Back-to-back fetches alternating between the address extremes.
        for (int i = 0; i < 10; i++)
            cycle(1, (i % 2) ? 14'h3FFF : 14'h0000, 0, 14'h0000, "alt");
        cycle(0, 14'h0000, 0, 14'h0000, "alt_idle");

        // Lone debug read: immediate grant, and no lingering promotion afterwards.
        cycle(0, 14'h0000, 1, 14'h0100, "dbg100");
        check_eq("dbg100/data_now", dbg_rdata, 16'h0100);
        cycle(1, 14'h0010, 1, 14'h0200, "dbg100_after");
        check_eq("dbg100/cpu_first", seen_dgnt, 0);
        cycle(0, 14'h0000, 0, 14'h0000, "idle");

        // Both requests continuous: debug should get one slot in every nine.
        dcount = 0; first_d = -1;
        for (int i = 0; i < 27; i++) begin
            cycle(1, 14'(i), 1, 14'h0200, "starve");
            if (seen_dgnt) begin
                dcount++;
                if (first_d < 0) first_d = i;
            end
        end
        check_eq("starve/dbg_count", dcount, 3);
        check_eq("starve/first_dbg", first_d, SMAX);
        cycle(0, 14'h0000, 0, 14'h0000, "idle2");

        // Reset in the cycle after a CPU grant cancels the returning word.
        cycle(1, 14'h0007, 0, 14'h0000, "pre_rst");
        rst_n = 0; cpu_req = 0;
        model_reset();
        #1;
        check_eq("midrst/cpu_vld",   cpu_vld,   0);
        check_eq("midrst/cpu_rdata", cpu_rdata, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1;
        cycle(0, 14'h0000, 0, 14'h0000, "post_rst");
        dcount = 0; first_d = -1;
        for (int i = 0; i < 10; i++) begin
            cycle(1, 14'h0020, 1, 14'h0300, "post_rst_starve");
            if (seen_dgnt && first_d < 0) first_d = i;
        end
        check_eq("post_rst/first_dbg", first_d, SMAX);
        cycle(0, 14'h0000, 0, 14'h0000, "idle3");

        // Random traffic; debug holds its request and address until granted.
        d_pend = 0; d_a = '0;
        for (int i = 0; i < 600; i++) begin
            if (!d_pend) begin
                d_pend = ($urandom_range(0, 2) == 0);
                case ($urandom_range(0, 3))
                    0:       d_a = 14'h0000;
                    1:       d_a = 14'h3FFF;
                    default: d_a = 14'($urandom);
                endcase
            end
            cr  = ($urandom_range(0, 9) < 8);
            c_a = ($urandom_range(0, 4) == 0) ? 14'h3FFF : 14'($urandom);
            cycle(cr, c_a, d_pend, d_a, "rand");
            if (m_gd) d_pend = 0;
        end
        cycle(0, 14'h0000, 0, 14'h0000, "drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
